snac_poll_scheduler: RTL and testbench
======================================

# snac_poll_scheduler

Sequences serial polling of two SNES-style game controllers on the Analogizer SNAC lines. It generates the shared latch and clock waveforms at a selectable poll rate, samples both players' data lines, and publishes 16-bit button words for the core's player-input mapping. It sits between the Analogizer cart-port pin logic and the core input path, and runs entirely in the system clock domain.

## Interface
Parameters:
- MASTER_CLK_FREQ, 96_000_000: i_clk frequency in Hz; must be an integer multiple of 1_000_000.

Ports:
- i_clk, in, 1: system clock.
- i_rst_l, in, 1: reset, asynchronous, active-low.
- i_ena, in, 1: polling enable; 0 holds the block in IDLE.
- i_rate, in, 3: sample-rate select. 0 compatibility, 1 normal, 2 fast, 3 superfast; values 4-7 behave as 3.
- i_p1_data, in, 1: P1 serial data, active-low, asynchronous.
- i_p2_data, in, 1: P2 serial data, active-low, asynchronous.
- o_latch, out, 1: shared latch, active-high.
- o_sclk, out, 1: shared serial clock; idles high.
- o_p1_btn, out, 16: P1 buttons, active-high; bit i = i-th serial bit.
- o_p2_btn, out, 16: P2 buttons, same format as o_p1_btn.
- o_busy, out, 1: high from LATCH entry through DONE.
- o_stb, out, 1: one-cycle pulse when new button words are published.

## Operation
- Prescaler: a 1 µs tick pulses once every TICK_DIV = MASTER_CLK_FREQ/1e6 cycles. It free-runs from reset, and every timer in the block advances only on tick.
- Rate table, giving half-bit time H and frame period F:
  - rate 0: H = 6 µs, F = 16000 µs
  - rate 1: H = 3 µs, F = 8000 µs
  - rate 2: H = 2 µs, F = 4000 µs
  - rate 3: H = 1 µs, F = 2000 µs
- i_rate is captured at LATCH entry; a change mid-frame takes effect at the next frame.
- Data inputs pass through 2-flop synchronizers before use.
- States:
  - IDLE: latch=0, sclk=1. When i_ena=1 and the frame timer has expired (or on the first tick after reset/enable), go to LATCH and restart the frame timer.
  - LATCH: latch=1 for 2H, then go to GAP.
  - GAP: latch=0 for H. At exit, sample bit 0 of both players into shadow registers, then go to SHIFT_LO with bit index 1.
  - SHIFT_LO: sclk=0 for H, then go to SHIFT_HI.
  - SHIFT_HI: sclk=1 for H. At exit, sample the current bit index and increment it. After bit 15 is sampled, go to DONE.
  - DONE: one cycle. Copy the inverted shadow registers to o_p1_btn and o_p2_btn, pulse o_stb, then go to IDLE.
- Button outputs change only in DONE, so both words update atomically.
- i_ena falling mid-sequence: finish the current frame, then stay in IDLE.
- Sequence length is 2H + H + 30H = 33H, always shorter than F. The frame timer's terminal count and the DONE cycle never conflict; if F expires while not in IDLE, that expiry is held pending until IDLE.

## Timing
- Reset values (asynchronous): o_latch=0, o_sclk=1, o_p1_btn=0, o_p2_btn=0, o_busy=0, o_stb=0, state IDLE, frame timer expired.
- State durations are whole ticks, with a ±1 tick phase uncertainty at LATCH entry only.
- Sampling happens in the same i_clk cycle as the tick that ends the phase. Synchronizer latency is 2 cycles, so data must be stable for 2 cycles before that tick.
- o_stb is exactly 1 cycle, in the same cycle the outputs update. o_busy falls the cycle after DONE.
- Reset asserted mid-frame: all outputs return to reset values immediately, with no partial publish.

## Structure
- Package snac_poll_pkg holds:
  - the state enum (IDLE, LATCH, GAP, SHIFT_LO, SHIFT_HI, DONE);
  - the rate-table constants H_US[4] and F_US[4];
  - the bit count constant NBITS=16.
- Sub-module us_tick_gen: prescaler parameterized by MASTER_CLK_FREQ, with outputs tick and the async active-low reset.

## Test plan
All scenarios use MASTER_CLK_FREQ=4_000_000, so 1 tick = 4 cycles.
- Waveform check: reset, i_ena=1, i_rate=3 -> latch high 8 cycles, low 4, then 15 sclk low/high pulses of 4 cycles each; next latch rises 8000 cycles after the first.
- Data capture: drive P1 serial pattern 16'hFFFE (bit0 low) and P2 16'h7FFF -> at o_stb, o_p1_btn=16'h0001 and o_p2_btn=16'h8000; o_stb is 1 cycle wide.
- Rate change mid-frame: start with rate 0, switch to rate 2 during SHIFT_LO -> current frame keeps H=24 cycles; next frame uses H=8 cycles and starts 64000 cycles after the previous latch.
- Disable: drop i_ena during GAP -> frame completes with o_stb; no further latch while i_ena=0; re-enable -> latch within 1 tick.
- Reset mid-shift: assert i_rst_l low at bit 7 -> o_latch=0, o_sclk=1, buttons=0, o_busy=0 in the same cycle; no o_stb.
- Rate 5 behaves identically to rate 3 (H=4 cycles, F=8000 cycles).

Source files
------------

// File: rtl/snac_poll_pkg.sv
// Shared types and rate-table constants for the SNAC controller poll scheduler.
package snac_poll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  localparam int NBITS = 16;
  localparam int PH_W  = 4;   // holds 2H-1 for the slowest rate
  localparam int FR_W  = 14;  // holds F-1 for the slowest rate

  localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);

  // Half-bit time and frame period in microseconds, indexed by rate select.
  localparam int H_US [4] = '{6, 3, 2, 1};
  localparam int F_US [4] = '{16000, 8000, 4000, 2000};

  // Rate values above 3 alias to the fastest setting.
  function automatic logic [1:0] rate_sel(input logic [2:0] rate);
    return rate[2] ? 2'd3 : rate[1:0];
  endfunction

  function automatic logic [PH_W-1:0] half_ticks(input logic [1:0] sel);
    return PH_W'(H_US[sel] - 1);
  endfunction

  function automatic logic [PH_W-1:0] latch_ticks(input logic [1:0] sel);
    return PH_W'(2 * H_US[sel] - 1);
  endfunction

  function automatic logic [FR_W-1:0] frame_ticks(input logic [1:0] sel);
    return FR_W'(F_US[sel] - 1);
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running 1 us tick prescaler; tick pulses for one i_clk cycle per microsecond.
module us_tick_gen #(
  parameter int MASTER_CLK_FREQ = 96_000_000
) (
  input  logic i_clk,
  input  logic i_rst_l,
  output logic tick
);

  localparam int TICK_DIV = MASTER_CLK_FREQ / 1_000_000;
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/snac_poll_scheduler.sv
// Generates SNES latch/clock waveforms for two SNAC controllers and publishes
// both players' 16-bit button words atomically once per frame.
module snac_poll_scheduler
  import snac_poll_pkg::*;
#(
  parameter int MASTER_CLK_FREQ = 96_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_l,
  input  logic        i_ena,
  input  logic [2:0]  i_rate,
  input  logic        i_p1_data,
  input  logic        i_p2_data,
  output logic        o_latch,
  output logic        o_sclk,
  output logic [15:0] o_p1_btn,
  output logic [15:0] o_p2_btn,
  output logic        o_busy,
  output logic        o_stb
);

  logic tick;

  us_tick_gen #(.MASTER_CLK_FREQ(MASTER_CLK_FREQ)) u_tick (
    .i_clk   (i_clk),
    .i_rst_l (i_rst_l),
    .tick    (tick)
  );

  state_t            state, state_nxt;
  logic [1:0]        rate_q;
  logic [PH_W-1:0]   ph_cnt;
  logic [FR_W-1:0]   frame_cnt;
  logic [3:0]        bit_idx;
  logic [NBITS-1:0]  sh1, sh2;
  logic [1:0]        p1_sync, p2_sync;
  logic              ph_end;
  logic [1:0]        rate_new;

  assign ph_end   = tick && (ph_cnt == '0);
  assign rate_new = rate_sel(i_rate);

  // Idle level of an open-drain pad is high (released), so synchronizers reset to 1.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      p1_sync <= 2'b11;
      p2_sync <= 2'b11;
    end else begin
      p1_sync <= {p1_sync[0], i_p1_data};
      p2_sync <= {p2_sync[0], i_p2_data};
    end
  end

  // NOTE: every variable written here is defaulted first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_ena && tick && frame_cnt == '0) state_nxt = LATCH;
      LATCH:    if (ph_end) state_nxt = GAP;
      GAP:      if (ph_end) state_nxt = SHIFT_LO;
      SHIFT_LO: if (ph_end) state_nxt = SHIFT_HI;
      SHIFT_HI: if (ph_end) state_nxt = (bit_idx == LAST_BIT) ? DONE : SHIFT_LO;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Pin-facing outputs are registered from the next state so they never glitch.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      state   <= IDLE;
      o_latch <= 1'b0;
      o_sclk  <= 1'b1;
      o_busy  <= 1'b0;
      o_stb   <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_latch <= (state_nxt == LATCH);
      o_sclk  <= (state_nxt != SHIFT_LO);
      o_busy  <= (state_nxt != IDLE);
      o_stb   <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      rate_q    <= '0;
      ph_cnt    <= '0;
      frame_cnt <= '0;
      bit_idx   <= '0;
      sh1       <= '0;
      sh2       <= '0;
      o_p1_btn  <= '0;
      o_p2_btn  <= '0;
    end else begin
      if (tick && ph_cnt != '0)    ph_cnt    <= ph_cnt - PH_W'(1);
      // Saturating at zero keeps an expiry pending until the FSM is back in IDLE.
      if (tick && frame_cnt != '0) frame_cnt <= frame_cnt - FR_W'(1);

      case (state)
        IDLE: begin
          if (!i_ena) begin
            frame_cnt <= '0;
          end else if (state_nxt == LATCH) begin
            rate_q    <= rate_new;
            ph_cnt    <= latch_ticks(rate_new);
            frame_cnt <= frame_ticks(rate_new);
          end
        end
        LATCH, SHIFT_LO: begin
          if (ph_end) ph_cnt <= half_ticks(rate_q);
        end
        GAP: begin
          if (ph_end) begin
            sh1[0]  <= p1_sync[1];
            sh2[0]  <= p2_sync[1];
            bit_idx <= 4'd1;
            ph_cnt  <= half_ticks(rate_q);
          end
        end
        SHIFT_HI: begin
          if (ph_end) begin
            sh1[bit_idx] <= p1_sync[1];
            sh2[bit_idx] <= p2_sync[1];
            bit_idx      <= bit_idx + 4'd1;
            ph_cnt       <= half_ticks(rate_q);
            // Publish on DONE entry, folding in the final bit sampled this cycle.
            if (bit_idx == LAST_BIT) begin
              o_p1_btn <= ~{p1_sync[1], sh1[NBITS-2:0]};
              o_p2_btn <= ~{p2_sync[1], sh2[NBITS-2:0]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snac_poll_scheduler.sv
// Directed bench for snac_poll_scheduler with a behavioural SNES controller pair.
module tb_snac_poll_scheduler;

  logic        i_clk   = 1'b0;
  logic        i_rst_l = 1'b1;
  logic        i_ena   = 1'b0;
  logic [2:0]  i_rate  = 3'd3;
  logic        i_p1_data, i_p2_data;
  logic        o_latch, o_sclk, o_busy, o_stb;
  logic [15:0] o_p1_btn, o_p2_btn;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  snac_poll_scheduler #(.MASTER_CLK_FREQ(4_000_000)) dut (
    .i_clk     (i_clk),
    .i_rst_l   (i_rst_l),
    .i_ena     (i_ena),
    .i_rate    (i_rate),
    .i_p1_data (i_p1_data),
    .i_p2_data (i_p2_data),
    .o_latch   (o_latch),
    .o_sclk    (o_sclk),
    .o_p1_btn  (o_p1_btn),
    .o_p2_btn  (o_p2_btn),
    .o_busy    (o_busy),
    .o_stb     (o_stb)
  );

  // Controller model: parallel load while latched, shift on each sclk rising edge.
  logic [15:0] p1_pat = 16'hFFFF, p2_pat = 16'hFFFF;
  logic [15:0] p1_sr  = 16'hFFFF, p2_sr  = 16'hFFFF;
  logic        sclk_d = 1'b1;

  always @(posedge i_clk) begin
    sclk_d <= o_sclk;
    if (o_latch) begin
      p1_sr <= p1_pat;
      p2_sr <= p2_pat;
    end else if (o_sclk && !sclk_d) begin
      p1_sr <= {1'b1, p1_sr[15:1]};
      p2_sr <= {1'b1, p2_sr[15:1]};
    end
  end

  assign i_p1_data = p1_sr[0];
  assign i_p2_data = p2_sr[0];

  typedef struct {
    int          t_rise;
    int          latch_w;
    int          gap_w;
    int          lo_c;
    int          hi_c;
    int          n_fall;
    int          stb_w;
    logic [15:0] p1;
    logic [15:0] p2;
    logic        busy_after;
  } frame_t;

  typedef struct {
    logic [2:0]  rate;
    logic [15:0] p1_pat;
    logic [15:0] p2_pat;
    logic [15:0] exp_p1;
    logic [15:0] exp_p2;
    int          hc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // mode 1: switch i_rate to new_rate at first sclk fall; mode 2: drop i_ena in GAP.
  task automatic capture(input int budget, input int mode, input logic [2:0] new_rate,
                         output frame_t f);
    int   n;
    logic prev;
    f = '{default: 0};
    n = 0;
    while (!o_latch && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_latch) begin
      check("latch_rise", o_latch, 1);
      return;
    end
    f.t_rise = cyc;
    while (o_latch && f.latch_w < 200) begin
      f.latch_w++;
      @(negedge i_clk);
    end
    while (!o_latch && o_sclk && !o_stb && f.gap_w < 200) begin
      if (mode == 2 && f.gap_w == 0) i_ena = 1'b0;
      f.gap_w++;
      @(negedge i_clk);
    end
    prev = 1'b1;
    n    = 0;
    while (!o_stb && n < 2000) begin
      if (!o_sclk) f.lo_c++;
      else         f.hi_c++;
      if (prev && !o_sclk) begin
        f.n_fall++;
        if (mode == 1 && f.n_fall == 1) i_rate = new_rate;
      end
      prev = o_sclk;
      n++;
      @(negedge i_clk);
    end
    f.p1 = o_p1_btn;
    f.p2 = o_p2_btn;
    n = 0;
    while (o_stb && n < 10) begin
      f.stb_w++;
      n++;
      @(negedge i_clk);
    end
    f.busy_after = o_busy;
  endtask

  task automatic check_frame(input string tag, input frame_t f, input int hc,
                             input logic [15:0] e1, input logic [15:0] e2);
    check({tag, "_latch_w"}, f.latch_w, 2 * hc);
    check({tag, "_gap_w"},   f.gap_w, hc);
    check({tag, "_n_sclk"},  f.n_fall, 15);
    check({tag, "_sclk_lo"}, f.lo_c, 15 * hc);
    check({tag, "_sclk_hi"}, f.hi_c, 15 * hc);
    check({tag, "_stb_w"},   f.stb_w, 1);
    check({tag, "_busy_end"}, f.busy_after, 0);
    check({tag, "_p1"},      f.p1, e1);
    check({tag, "_p2"},      f.p2, e2);
  endtask

  // Forces an immediate frame start: a short disable in IDLE expires the frame timer.
  task automatic restart(input logic [2:0] r);
    int n = 0;
    while (o_busy && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check("restart_idle", o_busy, 0);
    i_ena = 1'b0;
    repeat (8) @(negedge i_clk);
    i_rate = r;
    i_ena  = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_latch"}, o_latch, 0);
    check({tag, "_sclk"},  o_sclk, 1);
    check({tag, "_p1"},    o_p1_btn, 0);
    check({tag, "_p2"},    o_p2_btn, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_stb"},   o_stb, 0);
  endtask

  initial begin
    frame_t f, g;
    vec_t   vecs [6];
    int     n, falls, n_lat, n_stb, t_en;
    logic   prev;

    vecs[0] = '{3'd0, 16'hFFFE, 16'h7FFF, 16'h0001, 16'h8000, 24};
    vecs[1] = '{3'd1, 16'hA5A5, 16'h0F0F, 16'h5A5A, 16'hF0F0, 12};
    vecs[2] = '{3'd2, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 8};
    vecs[3] = '{3'd3, 16'h1234, 16'hFEDC, 16'hEDCB, 16'h0123, 4};
    vecs[4] = '{3'd5, 16'h5555, 16'hC3C3, 16'hAAAA, 16'h3C3C, 4};
    vecs[5] = '{3'd7, 16'hBFFD, 16'h8001, 16'h4002, 16'h7FFE, 4};

    // Asynchronous reset, observed before any clock edge.
    #2 i_rst_l = 1'b0;
    #1 check_reset_outputs("rst");

    repeat (3) @(negedge i_clk);
    p1_pat  = 16'hFFFE;
    p2_pat  = 16'h7FFF;
    i_rate  = 3'd3;
    i_ena   = 1'b1;
    i_rst_l = 1'b1;

    capture(20, 0, 3'd0, f);
    check_frame("wave", f, 4, 16'h0001, 16'h8000);
    capture(9000, 0, 3'd0, g);
    check("period_r3", g.t_rise - f.t_rise, 8000);

    for (int i = 0; i < 6; i++) begin
      p1_pat = vecs[i].p1_pat;
      p2_pat = vecs[i].p2_pat;
      restart(vecs[i].rate);
      capture(20, 0, 3'd0, f);
      check_frame($sformatf("vec%0d", i), f, vecs[i].hc, vecs[i].exp_p1, vecs[i].exp_p2);
    end

    // Rate switch from 0 to 2 during SHIFT_LO only affects the following frame.
    p1_pat = 16'h00F0;
    p2_pat = 16'hFF0F;
    restart(3'd0);
    capture(20, 1, 3'd2, f);
    check_frame("rchg_a", f, 24, 16'hFF0F, 16'h00F0);
    capture(66000, 0, 3'd0, g);
    check("period_r0", g.t_rise - f.t_rise, 64000);
    check_frame("rchg_b", g, 8, 16'hFF0F, 16'h00F0);

    // Disable during GAP: frame still completes, then nothing until re-enabled.
    p1_pat = 16'h00FF;
    p2_pat = 16'hF00F;
    restart(3'd3);
    capture(20, 2, 3'd0, f);
    check_frame("dis", f, 4, 16'hFF00, 16'h0FF0);
    n_lat = 0;
    repeat (8400) begin
      @(negedge i_clk);
      if (o_latch) n_lat++;
    end
    check("dis_no_latch", n_lat, 0);
    t_en  = cyc;
    i_ena = 1'b1;
    capture(5, 0, 3'd0, g);
    check("reen_within_tick", (g.t_rise - t_en) <= 4, 1);
    check_frame("reen", g, 4, 16'hFF00, 16'h0FF0);

    // Reset in the middle of bit 7: outputs clear at once, no publish.
    p1_pat = 16'h0000;
    p2_pat = 16'h0000;
    restart(3'd3);
    n = 0;
    while (!o_latch && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    falls = 0;
    prev  = 1'b1;
    n     = 0;
    while (falls < 7 && n < 500) begin
      @(negedge i_clk);
      if (prev && !o_sclk) falls++;
      prev = o_sclk;
      n++;
    end
    check("mid_falls", falls, 7);
    check("mid_busy", o_busy, 1);
    check("mid_sclk", o_sclk, 0);
    check("mid_p1_prev", o_p1_btn, 16'hFF00);
    #2 i_rst_l = 1'b0;
    #1 check_reset_outputs("mid_rst");
    i_ena = 1'b0;
    n_stb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (k == 3) i_rst_l = 1'b1;
      if (o_stb || o_p1_btn != 16'h0000) n_stb++;
    end
    check("mid_no_publish", n_stb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
